// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types, grant encodings and width defaults for regfile_write_arbiter.
package regarb_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GID_WB   = 2'd0,
        GID_LD   = 2'd1,
        GID_DBG  = 2'd2,
        GID_NONE = 2'd3
    } gid_e;

endpackage

// File: rtl/regfile_write_arbiter_starve_ctr.sv
// Saturating count of consecutive lost arbitration cycles for one requester;
// flags promotion once the count reaches STARVE_MAX while still requesting.
module regarb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic grant_i,
    output logic promoted_o
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!valid_i || grant_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STARVE_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign promoted_o = valid_i && (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter (WB > LD > DBG with starvation promotion, freeze/drain).
// Optional busy-bit scoreboard enabled by defining REGARB_SCOREBOARD_EN.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              wbValid,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbData,
    output logic              wbReady,
    input  logic              ldValid,
    input  logic [ADDR_W-1:0] ldAddr,
    input  logic [DATA_W-1:0] ldData,
    output logic              ldReady,
    input  logic              dbgValid,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [DATA_W-1:0] dbgData,
    output logic              dbgReady,
    input  logic              freeze,
`ifdef REGARB_SCOREBOARD_EN
    input  logic              rsvValid,
    input  logic [ADDR_W-1:0] rsvAddr,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    output logic              busy1,
    output logic              busy2,
`endif
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEnable,
    output logic              frozen,
    output logic [1:0]        grantId
);

    state_e            state_q, state_d;
    logic              regWrite_q, regWrite_d;
    logic [ADDR_W-1:0] writeReg_q, writeReg_d;
    logic [DATA_W-1:0] writeData_q, writeData_d;
    gid_e              gid_q, gid_d;
    logic              we_q, we_d;

    logic              ld_prom, dbg_prom;
    logic              wb_gnt, ld_gnt, dbg_gnt, xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    gid_e              sel_gid;

    regarb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_ld_ctr (
        .clk_i(Clk), .rst_i(Rst), .valid_i(ldValid), .grant_i(ld_gnt), .promoted_o(ld_prom)
    );

    regarb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_dbg_ctr (
        .clk_i(Clk), .rst_i(Rst), .valid_i(dbgValid), .grant_i(dbg_gnt), .promoted_o(dbg_prom)
    );

    always_comb begin
        wb_gnt   = 1'b0;
        ld_gnt   = 1'b0;
        dbg_gnt  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        sel_gid  = GID_NONE;
        if (!Rst && state_q == ST_RUN && !freeze) begin
            if (ld_prom)       ld_gnt  = 1'b1;
            else if (dbg_prom) dbg_gnt = 1'b1;
            else if (wbValid)  wb_gnt  = 1'b1;
            else if (ldValid)  ld_gnt  = 1'b1;
            else if (dbgValid) dbg_gnt = 1'b1;
        end
        if (wb_gnt) begin
            sel_addr = wbAddr;  sel_data = wbData;  sel_gid = GID_WB;
        end else if (ld_gnt) begin
            sel_addr = ldAddr;  sel_data = ldData;  sel_gid = GID_LD;
        end else if (dbg_gnt) begin
            sel_addr = dbgAddr; sel_data = dbgData; sel_gid = GID_DBG;
        end
    end

    assign xfer = wb_gnt || ld_gnt || dbg_gnt;

    always_comb begin
        state_d     = state_q;
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        gid_d       = GID_NONE;
        case (state_q)
            // freeze blocks grants, so only an in-flight regWrite can be outstanding here
            ST_RUN:    if (freeze) state_d = regWrite_q ? ST_DRAIN : ST_FROZEN;
            ST_DRAIN:  state_d = ST_FROZEN;
            ST_FROZEN: if (!freeze) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
        if (xfer && sel_addr != '0) begin
            regWrite_d  = 1'b1;
            writeReg_d  = sel_addr;
            writeData_d = sel_data;
            gid_d       = sel_gid;
        end
        we_d = (state_d != ST_FROZEN);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_RUN;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            gid_q       <= GID_NONE;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            gid_q       <= gid_d;
            we_q        <= we_d;
        end
    end

    assign wbReady     = wb_gnt;
    assign ldReady     = ld_gnt;
    assign dbgReady    = dbg_gnt;
    assign regWrite    = regWrite_q;
    assign writeReg    = writeReg_q;
    assign writeData   = writeData_q;
    assign writeEnable = we_q;
    assign frozen      = (state_q == ST_FROZEN);
    assign grantId     = gid_q;

`ifdef REGARB_SCOREBOARD_EN
    localparam int unsigned NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q, busy_d;

    // set is applied after clear so a same-cycle reservation survives the write
    always_comb begin
        busy_d = busy_q;
        if (regWrite_q) busy_d[writeReg_q] = 1'b0;
        if (rsvValid && rsvAddr != '0) busy_d[rsvAddr] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[rdAddr1];
    assign busy2 = busy_q[rdAddr2];
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table with an
// expected-write queue, plus hand sequences for reset and scoreboard cases.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Rst;
    logic        wbValid, ldValid, dbgValid;
    logic [4:0]  wbAddr, ldAddr, dbgAddr;
    logic [31:0] wbData, ldData, dbgData;
    logic        wbReady, ldReady, dbgReady;
    logic        freeze;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        writeEnable;
    logic        frozen;
    logic [1:0]  grantId;
`ifdef REGARB_SCOREBOARD_EN
    logic        rsvValid;
    logic [4:0]  rsvAddr, rdAddr1, rdAddr2;
    logic        busy1, busy2;
`endif

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData), .wbReady(wbReady),
        .ldValid(ldValid), .ldAddr(ldAddr), .ldData(ldData), .ldReady(ldReady),
        .dbgValid(dbgValid), .dbgAddr(dbgAddr), .dbgData(dbgData), .dbgReady(dbgReady),
        .freeze(freeze),
`ifdef REGARB_SCOREBOARD_EN
        .rsvValid(rsvValid), .rsvAddr(rsvAddr), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
        .busy1(busy1), .busy2(busy2),
`endif
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .writeEnable(writeEnable), .frozen(frozen), .grantId(grantId)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        wbV;  logic [4:0] wbA;  logic [31:0] wbD;
        logic        ldV;  logic [4:0] ldA;  logic [31:0] ldD;
        logic        dbgV; logic [4:0] dbgA; logic [31:0] dbgD;
        logic        frz;
        logic        eWb, eLd, eDbg, eWe, eFrz;
        string       nm;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  gid;
        string       nm;
    } exp_t;

    vec_t tbl[$];
    exp_t expq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wv, input logic [4:0] wa, input logic [31:0] wd,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic dv, input logic [4:0] da, input logic [31:0] dd,
        input logic fz, input logic ew, input logic el, input logic ed,
        input logic ewe, input logic efz, input string nm);
        vec_t v;
        v.wbV = wv;  v.wbA = wa;  v.wbD = wd;
        v.ldV = lv;  v.ldA = la;  v.ldD = ld;
        v.dbgV = dv; v.dbgA = da; v.dbgD = dd;
        v.frz = fz;
        v.eWb = ew; v.eLd = el; v.eDbg = ed; v.eWe = ewe; v.eFrz = efz;
        v.nm = nm;
        return v;
    endfunction

    task automatic idle_inputs();
        wbValid = 0; wbAddr = '0; wbData = '0;
        ldValid = 0; ldAddr = '0; ldData = '0;
        dbgValid = 0; dbgAddr = '0; dbgData = '0;
        freeze = 0;
`ifdef REGARB_SCOREBOARD_EN
        rsvValid = 0; rsvAddr = '0; rdAddr1 = '0; rdAddr2 = '0;
`endif
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int   wins;
        logic got;

        idle_inputs();

        // ---- Reset: Rst high for two cycles with requests pending ----
        Rst = 1; wbValid = 1; wbAddr = 5'd3; ldValid = 1; ldAddr = 5'd4; dbgValid = 1; dbgAddr = 5'd6;
        next_cycle();
        next_cycle();
        #2;
        chk("rst_wbReady",  32'(wbReady),  32'd0);
        chk("rst_ldReady",  32'(ldReady),  32'd0);
        chk("rst_dbgReady", 32'(dbgReady), 32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_writeReg", 32'(writeReg), 32'd0);
        chk("rst_writeData", writeData,    32'd0);
        chk("rst_writeEnable", 32'(writeEnable), 32'd0);
        chk("rst_frozen",   32'(frozen),   32'd0);
        chk("rst_grantId",  32'(grantId),  32'd3);
        next_cycle();
        Rst = 0;
        idle_inputs();
        #2;
        chk("rel_writeEnable_still0", 32'(writeEnable), 32'd0);
        next_cycle();
        chk("rel_writeEnable_1", 32'(writeEnable), 32'd1);
        chk("rel_regWrite", 32'(regWrite), 32'd0);

        // ---- Vector table ----
        tbl.push_back(mk(1,10,32'h11112222, 0,0,0, 0,0,0, 0, 1,0,0, 1,0, "single_wb"));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(1,1,32'hA0000000 + i, 1,2,32'hB0000002, 0,0,0, 0, 1,0,0, 1,0, "cont_wb_win"));
        tbl.push_back(mk(1,1,32'hA0000005, 1,2,32'hB0000002, 0,0,0, 0, 0,1,0, 1,0, "cont_ld_promoted"));
        tbl.push_back(mk(1,1,32'hA0000005, 0,0,0, 0,0,0, 0, 1,0,0, 1,0, "cont_wb_resume"));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0, "idle"));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(1,3,32'hC0000000 + i, 1,4,32'hD0000004, 1,7,32'hE0000007, 0, 1,0,0, 1,0, "tri_wb_win"));
        tbl.push_back(mk(1,3,32'hC0000005, 1,4,32'hD0000004, 1,7,32'hE0000007, 0, 0,1,0, 1,0, "tri_ld_over_dbg"));
        tbl.push_back(mk(1,3,32'hC0000005, 0,0,0, 1,7,32'hE0000007, 0, 0,0,1, 1,0, "tri_dbg_promoted"));
        tbl.push_back(mk(1,3,32'hC0000005, 0,0,0, 0,0,0, 0, 1,0,0, 1,0, "tri_wb_resume"));
        tbl.push_back(mk(0,0,0, 1,4,32'hD0000044, 1,7,32'hE0000077, 0, 0,1,0, 1,0, "prio_ld_gt_dbg"));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,7,32'hE0000077, 0, 0,0,1, 1,0, "dbg_alone"));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0,32'hDEADBEEF, 0, 0,0,1, 1,0, "addr0_dbg"));
        tbl.push_back(mk(1,8,32'h88888888, 0,0,0, 0,0,0, 0, 1,0,0, 1,0, "frz_wb_reg8"));
        tbl.push_back(mk(1,9,32'h99999999, 0,0,0, 0,0,0, 1, 0,0,0, 1,0, "frz_raise"));
        tbl.push_back(mk(1,9,32'h99999999, 0,0,0, 0,0,0, 1, 0,0,0, 1,0, "frz_drain"));
        tbl.push_back(mk(1,9,32'h99999999, 0,0,0, 0,0,0, 1, 0,0,0, 0,1, "frz_frozen"));
        tbl.push_back(mk(1,9,32'h99999999, 0,0,0, 0,0,0, 0, 0,0,0, 0,1, "frz_drop"));
        tbl.push_back(mk(1,9,32'h99999999, 0,0,0, 0,0,0, 0, 1,0,0, 1,0, "frz_run_again"));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0, "idle_end"));

        foreach (tbl[i]) begin
            v = tbl[i];
            wbValid = v.wbV;   wbAddr = v.wbA;   wbData = v.wbD;
            ldValid = v.ldV;   ldAddr = v.ldA;   ldData = v.ldD;
            dbgValid = v.dbgV; dbgAddr = v.dbgA; dbgData = v.dbgD;
            freeze = v.frz;
            #2;
            chk({v.nm, "_wbReady"},  32'(wbReady),     32'(v.eWb));
            chk({v.nm, "_ldReady"},  32'(ldReady),     32'(v.eLd));
            chk({v.nm, "_dbgReady"}, 32'(dbgReady),    32'(v.eDbg));
            chk({v.nm, "_writeEn"},  32'(writeEnable), 32'(v.eWe));
            chk({v.nm, "_frozen"},   32'(frozen),      32'(v.eFrz));
            e.rw = 0; e.a = '0; e.d = '0; e.gid = 2'd3; e.nm = v.nm;
            if (v.eWb)       begin e.a = v.wbA;  e.d = v.wbD;  e.gid = 2'd0; end
            else if (v.eLd)  begin e.a = v.ldA;  e.d = v.ldD;  e.gid = 2'd1; end
            else if (v.eDbg) begin e.a = v.dbgA; e.d = v.dbgD; e.gid = 2'd2; end
            if ((v.eWb || v.eLd || v.eDbg) && e.a != 5'd0) e.rw = 1;
            else e.gid = 2'd3;
            expq.push_back(e);
            next_cycle();
            e = expq.pop_front();
            chk({e.nm, "_regWrite"}, 32'(regWrite), 32'(e.rw));
            chk({e.nm, "_grantId"},  32'(grantId),  32'(e.gid));
            if (e.rw) begin
                chk({e.nm, "_writeReg"},  32'(writeReg), 32'(e.a));
                chk({e.nm, "_writeData"}, writeData,     e.d);
            end
        end

        // ---- Reset mid-operation ----
        wbValid = 1; wbAddr = 5'd12; wbData = 32'h12121212;
        ldValid = 1; ldAddr = 5'd13; ldData = 32'h13131313;
        #2;
        chk("mid_pre_wbReady", 32'(wbReady), 32'd1);
        next_cycle();
        wbAddr = 5'd14; wbData = 32'h14141414;
        Rst = 1;
        #2;
        chk("mid_rst_wbReady", 32'(wbReady), 32'd0);
        chk("mid_rst_ldReady", 32'(ldReady), 32'd0);
        next_cycle();
        Rst = 0;
        chk("mid_post_regWrite", 32'(regWrite), 32'd0);
        chk("mid_post_grantId",  32'(grantId),  32'd3);
        chk("mid_post_writeEn",  32'(writeEnable), 32'd0);
        wins = 0;
        got  = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            #2;
            if (ldReady) got = 1;
            else if (wbReady) wins++;
            next_cycle();
        end
        chk("mid_ld_grant_seen", 32'(got), 32'd1);
        chk("mid_wb_wins_after_reset", 32'(wins), 32'd4);
        idle_inputs();
        next_cycle();

`ifdef REGARB_SCOREBOARD_EN
        // ---- Busy-bit scoreboard ----
        rdAddr1 = 5'd5; rdAddr2 = 5'd0;
        rsvValid = 1; rsvAddr = 5'd5;
        next_cycle();
        rsvAddr = 5'd0;
        chk("sb_busy1_after_rsv", 32'(busy1), 32'd1);
        next_cycle();
        rsvValid = 0;
        chk("sb_addr0_ignored", 32'(busy2), 32'd0);
        ldValid = 1; ldAddr = 5'd5; ldData = 32'h55555555;
        #2;
        chk("sb_ld_ready", 32'(ldReady), 32'd1);
        next_cycle();
        ldValid = 0;
        chk("sb_regWrite5", 32'(regWrite), 32'd1);
        chk("sb_busy1_during_write", 32'(busy1), 32'd1);
        next_cycle();
        chk("sb_busy1_cleared", 32'(busy1), 32'd0);
        rdAddr2 = 5'd6; rsvValid = 1; rsvAddr = 5'd6;
        next_cycle();
        rsvValid = 0;
        ldValid = 1; ldAddr = 5'd6; ldData = 32'h66666666;
        next_cycle();
        ldValid = 0;
        rsvValid = 1; rsvAddr = 5'd6;
        chk("sb_regWrite6", 32'(regWrite), 32'd1);
        next_cycle();
        rsvValid = 0;
        chk("sb_set_wins", 32'(busy2), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between three requesters:
  - core writeback (WB)
  - load return (LD)
  - debug host (DBG)
- Arbitrates with fixed priority plus starvation promotion, registers the winning write, and drives regWrite/writeReg/writeData/writeEnable into the register file.
- Supports a freeze mode that drains any accepted write, then locks the write port for debug inspection.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- STARVE_MAX, 4, consecutive lost arbitration cycles before LD or DBG is promoted

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- wbValid/ldValid/dbgValid  in  1 each  request valid
- wbAddr/ldAddr/dbgAddr  in  ADDR_W each  destination register
- wbData/ldData/dbgData  in  DATA_W each  write data
- wbReady/ldReady/dbgReady  out  1 each  grant; transfer when valid&&ready
- freeze  in  1  request write-port lock
- regWrite  out  1  write strobe to register file
- writeReg  out  ADDR_W  write address
- writeData  out  DATA_W  write data
- writeEnable  out  1  global write unlock to register file
- frozen  out  1  high in FROZEN state
- grantId  out  2  source of current regWrite: 0=WB, 1=LD, 2=DBG, 3=none

Behaviour:
- Reset (Rst high at edge):
  - regWrite=0, writeReg=0, writeData=0, writeEnable=0, frozen=0, grantId=3.
  - Starvation counters cleared; state=RUN.
  - Ready outputs are 0 while Rst is high.
- Ready outputs:
  - Combinational from valids, counters and state.
  - At most one ready high per cycle, and only in RUN with freeze low.
- Priority: WB > LD > DBG.
  - A requester whose counter equals STARVE_MAX is promoted above WB.
  - If LD and DBG are both promoted, LD wins.
- Starvation counters (LD, DBG):
  - Increment when valid and not granted, saturating at STARVE_MAX.
  - Clear on grant or when valid is low.
- Requester obligations:
  - Hold valid/addr/data stable until ready.
  - Valid may not be dropped before ready.
- Latency:
  - A transfer in cycle N produces regWrite=1 with the captured addr/data in cycle N+1, for exactly one cycle.
  - Back-to-back grants are allowed every cycle.
- Address 0:
  - The transfer completes (ready high) but regWrite stays 0 and grantId=3.
  - The write is dropped silently.
- FSM states: RUN, DRAIN, FROZEN.
  - RUN, freeze low: arbitrate normally.
  - RUN, freeze high: no new grants. If a write was accepted this cycle or is outstanding, go to DRAIN; else go to FROZEN.
  - DRAIN: the pending regWrite issues; go to FROZEN next cycle.
  - FROZEN: writeEnable=0, frozen=1, no grants. When freeze is low, go to RUN next cycle.
  - Freeze and a grant never coincide: freeze high blocks all ready outputs in the same cycle.
- writeEnable:
  - Registered; 1 in RUN and DRAIN, 0 in FROZEN.
  - First rises one cycle after Rst deasserts.
- Reset mid-operation:
  - Any captured but unissued write is discarded.
  - Counters clear; no regWrite is emitted in the cycle after reset.

Optional Feature:
- Macro: REGARB_SCOREBOARD_EN.
- With the macro defined, these ports are added:
  - rsvValid in 1
  - rsvAddr in ADDR_W
  - rdAddr1 in ADDR_W
  - rdAddr2 in ADDR_W
  - busy1 out 1
  - busy2 out 1
- Scoreboard behaviour:
  - A 2^ADDR_W busy-bit vector is kept.
  - rsvValid sets bit rsvAddr; a reservation of address 0 is ignored.
  - An issued regWrite clears bit writeReg.
  - If set and clear hit the same address in the same cycle, the set wins.
  - busy1/busy2 are combinational lookups of rdAddr1/rdAddr2.
  - Reset clears the whole vector.
- Without the macro: none of these ports or logic exist.

Decomposition:
- Package regarb_pkg holds:
  - state enum (RUN, DRAIN, FROZEN)
  - grantId encodings (GID_WB=0, GID_LD=1, GID_DBG=2, GID_NONE=3)
  - ADDR_W/DATA_W defaults
- One natural sub-module: regarb_starve_ctr, a saturating wait counter instantiated for LD and DBG.

Test Plan:
- Reset:
  - Stimulus: hold Rst high 2 cycles, then release.
  - Required: all outputs at reset values; writeEnable=1 one cycle after release; no ready while Rst is high.
- Single write:
  - Stimulus: wbValid, wbAddr=10, wbData=32'h11112222 for one cycle.
  - Required: wbReady the same cycle; next cycle regWrite=1, writeReg=10, writeData=32'h11112222, grantId=0.
- Contention:
  - Stimulus: WB and LD both valid continuously, STARVE_MAX=4.
  - Required: WB wins 4 cycles; LD is granted on the 5th; WB resumes after.
- Address 0:
  - Stimulus: dbgValid with dbgAddr=0, dbgData=32'hDEADBEEF.
  - Required: dbgReady=1; next cycle regWrite=0, grantId=3.
- Freeze during a write:
  - Stimulus: WB transfer to reg 8, then freeze raised the next cycle.
  - Required: regWrite for reg 8 issues; then FROZEN with writeEnable=0 and frozen=1; all ready low while frozen. Drop freeze → RUN one cycle later.
- Scoreboard (with REGARB_SCOREBOARD_EN):
  - Stimulus: reserve reg 5, set rdAddr1=5; then an LD write to reg 5.
  - Required: busy1=1 after the reservation; busy1=0 the cycle after regWrite to reg 5 issues.
